// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_types
// Description : Shared RV32I front-end types: PC word, opcode enumeration,
//               register-field bundle, fetch FSM state encoding and a PC
//               word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef logic [31:0] rv32i_pc_word;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } rv32i_opcode;

    // Field order gives the {rs1, rs2, rd} packing used on the IF/ID boundary.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } rv32i_reg_word;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Instructions are word aligned; low address bits are discarded.
    function automatic rv32i_pc_word align_word(input rv32i_pc_word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : rv32i_types
`default_nettype wire

// File: rtl/instr_predecode.sv
`default_nettype none
// ============================================================================
// Module      : instr_predecode
// Description : Purely combinational slicing of a 32-bit RV32I instruction
//               word into opcode, funct3, funct7 and register fields.
// Ports       : i_instr   - instruction word
//               o_opcode  - instr[6:0]
//               o_funct3  - instr[14:12]
//               o_funct7  - instr[31:25]
//               o_regs    - {rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7]}
// Revision    : 1.0 - initial release
// ============================================================================
module instr_predecode
    import rv32i_types::*;
(
    input  logic [31:0]   i_instr,
    output rv32i_opcode   o_opcode,
    output logic [2:0]    o_funct3,
    output logic [6:0]    o_funct7,
    output rv32i_reg_word o_regs
);

    // The cast passes through encodings outside the enum (e.g. all-zero
    // when the buffer is empty); consumers treat those as illegal/invalid.
    assign o_opcode    = rv32i_opcode'(i_instr[6:0]);
    assign o_funct3    = i_instr[14:12];
    assign o_funct7    = i_instr[31:25];
    assign o_regs.rs1  = i_instr[19:15];
    assign o_regs.rs2  = i_instr[24:20];
    assign o_regs.rd   = i_instr[11:7];

endmodule : instr_predecode
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, keeps at most one
//               instruction-memory request outstanding, buffers the returned
//               word and presents its pre-decoded fields to reg_if_id.
//               Handles downstream stall and control-flow redirect, squashing
//               any fetch that is in flight when a redirect arrives.
// Ports       : clk, rst (async, active-low)
//               imem_req/imem_addr/imem_ready      - request channel
//               imem_resp/imem_rdata               - response channel
//               stall, redirect, redirect_pc       - control from later stages
//               valid_if, load_if_id, pc_if,
//               opcode_if, funct3_if, funct7_if,
//               regs_if                            - IF/ID interface
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import rv32i_types::*;
#(
    parameter rv32i_pc_word RESET_PC = 32'h4000_0060,
    parameter rv32i_pc_word PC_INC   = 32'd4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output rv32i_pc_word  imem_addr,
    input  logic          imem_ready,
    input  logic          imem_resp,
    input  logic [31:0]   imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  rv32i_pc_word  redirect_pc,
    output logic          valid_if,
    output logic          load_if_id,
    output rv32i_pc_word  pc_if,
    output rv32i_opcode   opcode_if,
    output logic [2:0]    funct3_if,
    output logic [6:0]    funct7_if,
    output rv32i_reg_word regs_if
);

    fetch_state_t r_state;
    rv32i_pc_word r_pc;
    logic         r_squash;
    logic [31:0]  r_buf_instr;
    rv32i_pc_word r_buf_pc;

    fetch_state_t w_state_nxt;
    rv32i_pc_word w_pc_nxt;
    logic         w_squash_nxt;
    logic [31:0]  w_buf_instr_nxt;
    rv32i_pc_word w_buf_pc_nxt;

    logic         w_imem_req;
    logic         w_valid;
    logic         w_load;
    rv32i_pc_word w_redirect_target;
    logic [31:0]  w_instr_view;

    assign w_redirect_target = align_word(redirect_pc);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_squash    <= 1'b0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_squash    <= w_squash_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_squash_nxt    = r_squash;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        w_imem_req      = 1'b0;
        w_valid         = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_state_nxt = WAIT;
                    // The accepted request targets the old PC, so its
                    // response must be thrown away.
                    if (redirect) begin
                        w_squash_nxt = 1'b1;
                        w_pc_nxt     = w_redirect_target;
                    end
                end else if (redirect) begin
                    // Nothing accepted yet: just retarget the pending request.
                    w_pc_nxt = w_redirect_target;
                end
            end

            WAIT: begin
                if (redirect) begin
                    w_pc_nxt     = w_redirect_target;
                    w_squash_nxt = 1'b1;
                end
                if (imem_resp) begin
                    if (r_squash || redirect) begin
                        // Overrides the squash set above when both coincide:
                        // the stale response is consumed this very cycle.
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = FETCH;
                    end else begin
                        w_buf_instr_nxt = imem_rdata;
                        w_buf_pc_nxt    = r_pc;
                        w_state_nxt     = HOLD;
                    end
                end
            end

            HOLD: begin
                w_valid = 1'b1;
                w_load  = ~stall & ~redirect;
                if (redirect) begin
                    w_buf_instr_nxt = '0;
                    w_buf_pc_nxt    = '0;
                    w_pc_nxt        = w_redirect_target;
                    w_state_nxt     = FETCH;
                end else if (!stall) begin
                    w_pc_nxt    = r_pc + PC_INC;
                    w_state_nxt = FETCH;
                end
            end

            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // Request outputs are forced low while reset is held, even though the
    // state register already sits in FETCH.
    assign imem_req   = w_imem_req & rst;
    assign imem_addr  = rst ? r_pc : '0;

    assign valid_if   = w_valid;
    assign load_if_id = w_load;
    assign pc_if      = w_valid ? r_buf_pc : '0;

    // Decoded fields read as zero whenever no instruction is buffered.
    assign w_instr_view = w_valid ? r_buf_instr : '0;

    instr_predecode u_predecode (
        .i_instr  (w_instr_view),
        .o_opcode (opcode_if),
        .o_funct3 (funct3_if),
        .o_funct7 (funct7_if),
        .o_regs   (regs_if)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. Accepted
//               responses are pushed to a scoreboard as {pc, instr}; every
//               load_if_id pulse pops one entry and compares it against the
//               IF/ID outputs reassembled into an instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import rv32i_types::*;

    logic          clk;
    logic          rst;
    logic          imem_req;
    rv32i_pc_word  imem_addr;
    logic          imem_ready;
    logic          imem_resp;
    logic [31:0]   imem_rdata;
    logic          stall;
    logic          redirect;
    rv32i_pc_word  redirect_pc;
    logic          valid_if;
    logic          load_if_id;
    rv32i_pc_word  pc_if;
    rv32i_opcode   opcode_if;
    logic [2:0]    funct3_if;
    logic [6:0]    funct7_if;
    rv32i_reg_word regs_if;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb[$];

    fetch_stage #(
        .RESET_PC (32'h4000_0060),
        .PC_INC   (32'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_resp   (imem_resp),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .valid_if    (valid_if),
        .load_if_id  (load_if_id),
        .pc_if       (pc_if),
        .opcode_if   (opcode_if),
        .funct3_if   (funct3_if),
        .funct7_if   (funct7_if),
        .regs_if     (regs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer, run at every sampling point.
    task automatic mon();
        logic [63:0] e;
        logic [31:0] got;
        if (load_if_id === 1'b1) begin
            chk("sb_load_expected", 32'(sb.size()), 32'd1);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                got = {funct7_if, regs_if.rs2, regs_if.rs1, funct3_if, regs_if.rd, 7'(opcode_if)};
                chk("sb_pc", pc_if, e[63:32]);
                chk("sb_instr", got, e[31:0]);
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: offer ready, confirm the address, end up in WAIT.
    task automatic accept(input logic [31:0] addr, input string tag);
        imem_ready = 1'b1;
        to_neg();
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
        to_pos();
        imem_ready = 1'b0;
    endtask

    // From WAIT: deliver one response; optionally expect it to be loaded.
    task automatic respond(input logic [31:0] data, input logic [31:0] pc, input bit keep);
        imem_resp  = 1'b1;
        imem_rdata = data;
        if (keep) sb.push_back({pc, data});
        to_neg();
        to_pos();
        imem_resp  = 1'b0;
        imem_rdata = '0;
    endtask

    initial begin
        rst = 1'b0; imem_ready = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset state
        to_pos(); to_pos();
        to_neg();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", 32'(valid_if), 32'd0);
        chk("rst_load", 32'(load_if_id), 32'd0);
        chk("rst_pc_if", pc_if, 32'd0);
        chk("rst_fields", {7'(opcode_if), funct3_if, funct7_if, regs_if}, 32'd0);
        to_pos();
        rst = 1'b1;

        // First fetch: addi x5,x5,10
        accept(32'h4000_0060, "f1");
        to_neg();
        chk("wait_req_low", 32'(imem_req), 32'd0);
        to_pos();
        respond(32'h00A2_8293, 32'h4000_0060, 1'b1);
        to_neg();
        chk("f1_valid", 32'(valid_if), 32'd1);
        chk("f1_load", 32'(load_if_id), 32'd1);
        chk("f1_opcode", 32'(opcode_if), 32'h13);
        chk("f1_funct3", 32'(funct3_if), 32'd0);
        chk("f1_regs", 32'(regs_if), {17'd0, 5'd5, 5'd10, 5'd5});
        to_pos();
        to_neg();
        chk("f1_valid_after", 32'(valid_if), 32'd0);
        to_pos();

        // Stall for 4 HOLD cycles: add x3,x1,x2
        accept(32'h4000_0064, "f2");
        stall = 1'b1;
        respond(32'h0020_81B3, 32'h4000_0064, 1'b1);
        for (int i = 0; i < 4; i++) begin
            to_neg();
            chk("stall_valid", 32'(valid_if), 32'd1);
            chk("stall_load", 32'(load_if_id), 32'd0);
            chk("stall_pc_if", pc_if, 32'h4000_0064);
            chk("stall_regs", 32'(regs_if), {17'd0, 5'd1, 5'd2, 5'd3});
            to_pos();
        end
        stall = 1'b0;
        to_neg();
        chk("unstall_load", 32'(load_if_id), 32'd1);
        to_pos();

        // Redirect in WAIT, response next cycle is squashed
        accept(32'h4000_0068, "f3");
        redirect = 1'b1; redirect_pc = 32'h4000_1003;
        to_neg();
        to_pos();
        redirect = 1'b0; redirect_pc = '0;
        respond(32'hDEAD_BEEF, 32'h0, 1'b0);
        to_neg();
        chk("rdw_valid", 32'(valid_if), 32'd0);
        chk("rdw_req", 32'(imem_req), 32'd1);
        chk("rdw_addr", imem_addr, 32'h4000_1000);
        to_pos();

        // Redirect and response in the same WAIT cycle
        accept(32'h4000_1000, "f4");
        redirect = 1'b1; redirect_pc = 32'h4000_2000;
        respond(32'hCAFE_F00D, 32'h0, 1'b0);
        redirect = 1'b0; redirect_pc = '0;
        to_neg();
        chk("rdsame_valid", 32'(valid_if), 32'd0);
        chk("rdsame_addr", imem_addr, 32'h4000_2000);
        to_pos();

        // Reset in WAIT, stray response in the first FETCH cycle
        accept(32'h4000_2000, "f5");
        rst = 1'b0;
        to_neg();
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        to_pos();
        rst = 1'b1;
        imem_resp = 1'b1; imem_rdata = 32'h1234_5678;
        to_neg();
        chk("stray_addr", imem_addr, 32'h4000_0060);
        chk("stray_valid", 32'(valid_if), 32'd0);
        to_pos();
        imem_resp = 1'b0; imem_rdata = '0;
        to_neg();
        chk("stray_after_valid", 32'(valid_if), 32'd0);
        chk("stray_after_req", 32'(imem_req), 32'd1);
        to_pos();

        // Redirect while unaccepted in FETCH; low bits forced to zero
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        to_neg();
        to_pos();
        redirect = 1'b0; redirect_pc = '0;

        // PC wrap
        accept(32'hFFFF_FFFC, "wrap");
        respond(32'h0000_0013, 32'hFFFF_FFFC, 1'b1);
        to_neg();
        chk("wrap_load", 32'(load_if_id), 32'd1);
        to_pos();
        to_neg();
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        to_pos();

        // Redirect coinciding with acceptance in FETCH
        imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000_3000;
        to_neg();
        to_pos();
        imem_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        respond(32'h0000_0013, 32'h0, 1'b0);
        to_neg();
        chk("rdacc_valid", 32'(valid_if), 32'd0);
        chk("rdacc_addr", imem_addr, 32'h4000_3000);
        to_pos();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage. Owns the PC and issues one instruction-memory request at a time.
- Buffers the returned instruction and pre-decodes opcode, funct3, funct7 and register fields.
- Presents those fields, with a load strobe, to the IF/ID pipeline register (reg_if_id) directly downstream.
- Honours a downstream stall and a redirect (branch/jump) from later stages, squashing in-flight fetches.

Parameters:
- RESET_PC, 32'h4000_0060, PC value loaded on reset.
- PC_INC, 4, PC increment per retired fetch.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  request address (rv32i_pc_word).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_resp  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- stall  in  1  downstream cannot accept an instruction this cycle.
- redirect  in  1  control-flow redirect.
- redirect_pc  in  32  redirect target.
- valid_if  out  1  buffered instruction valid.
- load_if_id  out  1  load strobe for reg_if_id.
- pc_if  out  32  PC of buffered instruction (rv32i_pc_word).
- opcode_if  out  7  instr[6:0] (rv32i_opcode).
- funct3_if  out  3  instr[14:12].
- funct7_if  out  7  instr[31:25].
- regs_if  out  15  {rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7]} (rv32i_reg_word).

Behaviour:
- Reset (rst=0, asynchronous):
  - pc <= RESET_PC; state <= FETCH; squash <= 0; buffer cleared.
  - All outputs 0, including imem_req and imem_addr (output is masked while rst=0).
- States: FETCH, WAIT, HOLD. At most one memory request outstanding.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ready=1: request accepted, go to WAIT.
  - If redirect=1 and imem_ready=0: pc <= redirect_pc, stay in FETCH. The address may change while the request is unaccepted.
  - If redirect=1 and imem_ready=1: go to WAIT, squash <= 1, pc <= redirect_pc.
- WAIT:
  - imem_req=0. Response arrives no earlier than the cycle after acceptance.
  - If redirect=1: pc <= redirect_pc and squash <= 1. Redirect has priority over a same-cycle response.
  - On imem_resp=1 with squash=1 or redirect=1: discard data, squash <= 0, go to FETCH.
  - On imem_resp=1 otherwise: capture imem_rdata and pc into the buffer, go to HOLD.
- HOLD:
  - valid_if=1; load_if_id = ~stall & ~redirect.
  - If redirect=1: drop the buffer, pc <= redirect_pc, go to FETCH, no load.
  - Else if stall=0: pc <= pc + PC_INC, go to FETCH.
  - Else (stall=1): hold all outputs unchanged.
- Decoded outputs:
  - Combinational slices of the buffer register; stable for the whole of HOLD.
  - All zero when valid_if=0.
- Width and address rules:
  - PC arithmetic is 32-bit, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - redirect_pc[1:0] is forced to 0.
- Throughput: minimum 3 cycles per instruction (FETCH accept, WAIT response, HOLD load).
- Boundary cases:
  - imem_resp outside WAIT is ignored.
  - Reset asserted mid-WAIT abandons the request; a late response after reset release arrives in FETCH and is ignored.
  - stall is ignored outside HOLD.

Decomposition:
- rv32i_types package holds:
  - rv32i_pc_word (32b).
  - rv32i_opcode enum (7b).
  - rv32i_reg_word packed struct {rs1, rs2, rd}, 5b each.
  - fetch_state_t enum {FETCH, WAIT, HOLD}.
- One natural sub-module, instr_predecode: purely combinational slicing of the instruction word into the rv32i fields, reusable by later decode.

Test Plan:
- Reset release, imem_ready=1, response 1 cycle later with rdata=32'h00A28293 (addi x5,x5,10), stall=0:
  - First request addr 32'h4000_0060.
  - HOLD shows opcode 7'h13, funct3 0, rs1 5, rd 5, load_if_id=1 for one cycle.
  - Next imem_addr 32'h4000_0064.
- stall=1 for 4 cycles during HOLD:
  - valid_if=1 throughout, load_if_id=0, outputs constant.
  - On stall=0, load_if_id=1 exactly once, then a fetch of pc+4.
- redirect=1, redirect_pc=32'h4000_1003, in WAIT, response the following cycle:
  - Response dropped, load_if_id never pulses.
  - Next imem_addr 32'h4000_1000.
- redirect and imem_resp in the same WAIT cycle: data dropped; next fetch addr = redirect target.
- rst pulled low in WAIT, released, stray imem_resp in the first FETCH cycle:
  - Response ignored, imem_addr=RESET_PC, valid_if=0.
- PC 32'hFFFF_FFFC fetched and retired: next imem_addr 32'h0000_0000.
